// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the fetch-side PC sequencer and the PC register:
//   FSM state encoding, sequential PC increment and the PC value after reset.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch
//   Remembers a branch/jump redirect that arrives while the PC cannot advance
//   and selects the next PC value.
// Ports:
//   clk, rst                      clock, async active-high reset
//   adv                           PC loads pc_next this cycle
//   capture_en                    redirects may be latched (not HALTED)
//   pc_cur                        current PC
//   branch_taken/branch_target    branch redirect
//   jump/jump_target              jump redirect
//   pc_next                       value for the PC input
//   flush_if                      redirect applied this cycle
module pc_redirect_latch #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        capture_en,
    input  logic [31:0] pc_cur,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_next,
    output logic        flush_if
);

    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q,  redir_tgt_d;
    logic        redir_any;
    logic [31:0] new_tgt;
    logic [31:0] pc_seq;

    always_comb begin
        redir_any    = branch_taken | jump;
        new_tgt      = branch_taken ? branch_target : jump_target;
        pc_seq       = pc_cur + PC_STEP;

        // Under reset the pending redirect is already clear; live redirect
        // inputs are masked so pc_next shows the plain sequential value.
        pc_next = pc_seq;
        if (!rst) begin
            if (redir_pend_q)   pc_next = redir_tgt_q;
            else if (redir_any) pc_next = new_tgt;
        end

        flush_if = ~rst & adv & (redir_pend_q | redir_any);

        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        if (adv) begin
            redir_pend_d = 1'b0;
        end else if (capture_en && !redir_pend_q && redir_any) begin
            // First redirect wins; anything after it is wrong-path.
            redir_pend_d = 1'b1;
            redir_tgt_d  = new_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0;
        end else begin
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-side controller driving the PC register controls. Sequences each
//   fetch against imem readiness and hazard stalls, arbitrates redirects and
//   parks on HALT (or imem timeout) until resume.
// Ports:
//   clk, reset          clock, async active-high reset
//   pc_cur              current PC
//   imem_ready          instruction word valid for pc_cur
//   hazard_stall        hazard unit freeze request
//   branch_taken/target, jump/jump_target  redirects
//   halt_instr          fetched word is HALT
//   resume              leave HALTED
//   pc_next, pc_halt, pc_stall, pc_confirm  PC register controls
//   imem_req            fetch request
//   flush_if            squash IF/ID
//   fetch_error         sticky imem timeout flag
module pc_sequencer #(
    parameter logic [31:0] PC_STEP = pc_sequencer_pkg::PC_STEP,
    parameter int          TIMEOUT = 15,
    parameter int          TW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        imem_ready,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_instr,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        pc_halt,
    output logic        pc_stall,
    output logic        pc_confirm,
    output logic        imem_req,
    output logic        flush_if,
    output logic        fetch_error
);
    import pc_sequencer_pkg::*;

    state_e          state_q, state_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            fetch_error_q, fetch_error_d;
    logic [TW-1:0]   wait_inc;
    logic            in_fetch, in_hold, in_halted;
    logic            adv;

    always_comb begin
        in_fetch  = (state_q == S_FETCH);
        in_hold   = (state_q == S_HOLD);
        in_halted = (state_q == S_HALTED);

        // Masked by reset so the PC never loads while reset is asserted.
        adv = ~reset & ((in_fetch & imem_ready & ~hazard_stall & ~halt_instr) |
                        (in_hold & ~hazard_stall));

        pc_halt     = in_halted;
        imem_req    = in_fetch;
        pc_stall    = in_halted ? 1'b0 : ~adv;
        pc_confirm  = adv;
        fetch_error = fetch_error_q;

        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_error_d = fetch_error_q;
        wait_inc      = wait_cnt_q + 1'b1;

        if (imem_ready) wait_cnt_d = '0;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (hazard_stall)    state_d = S_HOLD;
                    else if (halt_instr) state_d = S_HALTED;
                end else if (wait_inc == TW'(TIMEOUT)) begin
                    // TIMEOUT consecutive not-ready cycles end the fetch.
                    fetch_error_d = 1'b1;
                    state_d       = S_HALTED;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_HOLD: begin
                if (!hazard_stall) state_d = S_FETCH;
            end
            S_HALTED: begin
                if (resume) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    pc_redirect_latch #(
        .PC_STEP (PC_STEP)
    ) u_redirect (
        .clk           (clk),
        .rst           (reset),
        .adv           (adv),
        .capture_en    (~in_halted),
        .pc_cur        (pc_cur),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_next       (pc_next),
        .flush_if      (flush_if)
    );

endmodule
